// File: rtl/ext_bus_decoder.sv
// Registered request decoder between the core's 512-bit external port and the rom/ram targets.
// Optional BUSY watchdog enabled by defining BUS_DECODER_TIMEOUT_EN.
module ext_bus_decoder #(
    parameter int          ADDR_W   = 32,
    parameter int          DATA_W   = 512,
    parameter logic [31:0] ROM_BASE = 32'h0000_0000,
    parameter logic [31:0] ROM_MASK = 32'hFFFF_8000,
    parameter logic [31:0] RAM_BASE = 32'h0000_8000,
    parameter logic [31:0] RAM_MASK = 32'hFFFF_C000
`ifdef BUS_DECODER_TIMEOUT_EN
    ,
    parameter int          TIMEOUT_CYCLES = 64
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              up_addr_valid,
    input  logic [ADDR_W-1:0] up_addr,
    input  logic              up_write_data_valid,
    input  logic [DATA_W-1:0] up_write_data,
    output logic              up_read_data_ready,
    output logic [DATA_W-1:0] up_read_data,
    output logic              up_error,
    output logic              rom_cs,
    output logic              ram_cs,
    output logic              dn_addr_valid,
    output logic [ADDR_W-1:0] dn_addr,
    output logic              dn_write_data_valid,
    output logic [DATA_W-1:0] dn_write_data,
    input  logic              rom_data_ready,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              ram_data_ready,
    input  logic [DATA_W-1:0] ram_data
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [1:0] ERR  = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              wr_q;
    logic              rom_sel_q;

    logic rom_hit;
    logic ram_hit;
    logic target_ready;

    assign rom_hit = ((up_addr & ROM_MASK[ADDR_W-1:0]) == ROM_BASE[ADDR_W-1:0]);
    assign ram_hit = ((up_addr & RAM_MASK[ADDR_W-1:0]) == RAM_BASE[ADDR_W-1:0]);

    // Only the selected target's handshake matters; the other one may be busy elsewhere.
    assign target_ready = rom_sel_q ? rom_data_ready : ram_data_ready;

`ifdef BUS_DECODER_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    logic        tmo_hit;
    assign tmo_hit = (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    logic tmo_hit;
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            wr_q      <= 1'b0;
            rom_sel_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (up_addr_valid) begin
                        addr_q    <= up_addr;
                        wr_q      <= up_write_data_valid;
                        wdata_q   <= up_write_data;
                        rom_sel_q <= rom_hit;
                        // rom wins overlaps; writes into rom are refused locally
                        if (rom_hit)
                            state <= up_write_data_valid ? ERR : BUSY;
                        else if (ram_hit)
                            state <= BUSY;
                        else
                            state <= ERR;
                    end
                end
                BUSY: begin
                    if (target_ready) begin
                        rdata_q <= wr_q ? '0 : (rom_sel_q ? rom_data : ram_data);
                        state   <= DONE;
                    end else if (tmo_hit) begin
                        state <= ERR;
                    end
                end
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BUS_DECODER_TIMEOUT_EN
    // Cleared while idle so every BUSY entry starts counting from zero.
    always_ff @(posedge clk) begin
        if (rst || state != BUSY)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + 16'd1;
    end
`endif

    assign rom_cs              = (state == BUSY) && rom_sel_q;
    assign ram_cs              = (state == BUSY) && !rom_sel_q;
    assign dn_addr_valid       = (state == BUSY);
    assign dn_write_data_valid = (state == BUSY) && wr_q;
    assign dn_addr             = addr_q;
    assign dn_write_data       = wdata_q;

    assign up_read_data_ready  = (state == DONE) || (state == ERR);
    assign up_error            = (state == ERR);
    assign up_read_data        = (state == DONE) ? rdata_q : '0;

endmodule

// File: tb/tb_ext_bus_decoder.sv
// Directed self-checking bench for ext_bus_decoder; outputs are sampled 1 time unit after posedge.
// The timeout scenario follows BUS_DECODER_TIMEOUT_EN, otherwise BUSY is checked to wait indefinitely.
module tb_ext_bus_decoder;

    logic         clk = 1'b0;
    logic         rst;
    logic         up_addr_valid;
    logic [31:0]  up_addr;
    logic         up_write_data_valid;
    logic [511:0] up_write_data;
    logic         up_read_data_ready;
    logic [511:0] up_read_data;
    logic         up_error;
    logic         rom_cs;
    logic         ram_cs;
    logic         dn_addr_valid;
    logic [31:0]  dn_addr;
    logic         dn_write_data_valid;
    logic [511:0] dn_write_data;
    logic         rom_data_ready;
    logic [511:0] rom_data;
    logic         ram_data_ready;
    logic [511:0] ram_data;

    int total = 0;
    int bad   = 0;

    localparam logic [511:0] ROM_PAT = {16{32'hDEAD_BEEF}};
    localparam logic [511:0] RAM_PAT = {16{32'h1234_5678}};
    localparam logic [511:0] WR_PAT  = {64{8'hA5}};

    ext_bus_decoder dut (
        .clk                 (clk),
        .rst                 (rst),
        .up_addr_valid       (up_addr_valid),
        .up_addr             (up_addr),
        .up_write_data_valid (up_write_data_valid),
        .up_write_data       (up_write_data),
        .up_read_data_ready  (up_read_data_ready),
        .up_read_data        (up_read_data),
        .up_error            (up_error),
        .rom_cs              (rom_cs),
        .ram_cs              (ram_cs),
        .dn_addr_valid       (dn_addr_valid),
        .dn_addr             (dn_addr),
        .dn_write_data_valid (dn_write_data_valid),
        .dn_write_data       (dn_write_data),
        .rom_data_ready      (rom_data_ready),
        .rom_data            (rom_data),
        .ram_data_ready      (ram_data_ready),
        .ram_data            (ram_data)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Presents one request for a single accept cycle; returns in cycle N+1.
    task automatic applyStimulus(input logic [31:0] addr, input logic wr, input logic [511:0] wdata);
        up_addr_valid       = 1'b1;
        up_addr             = addr;
        up_write_data_valid = wr;
        up_write_data       = wdata;
        tick;
        up_addr_valid       = 1'b0;
        up_write_data_valid = 1'b0;
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_ready"}, 512'(up_read_data_ready), 512'(1'b0));
        checkOutput({tag, "_err"},   512'(up_error), 512'(1'b0));
        checkOutput({tag, "_data"},  up_read_data, '0);
        checkOutput({tag, "_cs"},    512'({rom_cs, ram_cs}), 512'(2'b00));
        checkOutput({tag, "_dnv"},   512'({dn_addr_valid, dn_write_data_valid}), 512'(2'b00));
    endtask

    // rom read whose target answers two cycles into BUSY.
    task automatic romRead(input string tag);
        applyStimulus(32'h0000_0100, 1'b0, '0);
        checkOutput({tag, "_cs1"}, 512'({rom_cs, ram_cs, dn_addr_valid}), 512'(3'b101));
        checkOutput({tag, "_addr"}, 512'(dn_addr), 512'(32'h0000_0100));
        tick;
        checkOutput({tag, "_cs2"}, 512'(rom_cs), 512'(1'b1));
        tick;
        rom_data_ready = 1'b1;
        checkOutput({tag, "_cs3"}, 512'(rom_cs), 512'(1'b1));
        checkOutput({tag, "_noready3"}, 512'(up_read_data_ready), 512'(1'b0));
        tick;
        rom_data_ready = 1'b0;
        checkOutput({tag, "_ready"}, 512'(up_read_data_ready), 512'(1'b1));
        checkOutput({tag, "_err"}, 512'(up_error), 512'(1'b0));
        checkOutput({tag, "_data"}, up_read_data, ROM_PAT);
        checkOutput({tag, "_csoff"}, 512'(rom_cs), 512'(1'b0));
        tick;
        checkQuiet({tag, "_after"});
    endtask

    initial begin
        rst                 = 1'b1;
        up_addr_valid       = 1'b0;
        up_addr             = '0;
        up_write_data_valid = 1'b0;
        up_write_data       = '0;
        rom_data_ready      = 1'b0;
        rom_data            = ROM_PAT;
        ram_data_ready      = 1'b0;
        ram_data            = RAM_PAT;
        tick;
        tick;
        checkQuiet("reset");
        checkOutput("reset_dnaddr", 512'(dn_addr), 512'(32'h0));
        checkOutput("reset_dnwdata", dn_write_data, '0);
        rst = 1'b0;
        tick;

        romRead("rom_rd");

        // ram write acknowledged immediately
        applyStimulus(32'h0000_8040, 1'b1, WR_PAT);
        ram_data_ready = 1'b1;
        checkOutput("ramwr_cs", 512'({rom_cs, ram_cs, dn_write_data_valid}), 512'(3'b011));
        checkOutput("ramwr_addr", 512'(dn_addr), 512'(32'h0000_8040));
        checkOutput("ramwr_wdata", dn_write_data, WR_PAT);
        tick;
        ram_data_ready = 1'b0;
        checkOutput("ramwr_ready", 512'({up_read_data_ready, up_error}), 512'(2'b10));
        checkOutput("ramwr_data", up_read_data, '0);
        checkOutput("ramwr_csoff", 512'({ram_cs, dn_write_data_valid}), 512'(2'b00));
        tick;

        // rom write held high past the error pulse is re-accepted as a new request
        up_addr_valid       = 1'b1;
        up_addr             = 32'h0000_0000;
        up_write_data_valid = 1'b1;
        up_write_data       = WR_PAT;
        tick;
        checkOutput("romwr_err", 512'({up_read_data_ready, up_error}), 512'(2'b11));
        checkOutput("romwr_cs", 512'({rom_cs, ram_cs, dn_addr_valid}), 512'(3'b000));
        checkOutput("romwr_data", up_read_data, '0);
        tick;
        checkOutput("romwr_idle", 512'(up_read_data_ready), 512'(1'b0));
        tick;
        checkOutput("romwr_again", 512'({up_read_data_ready, up_error}), 512'(2'b11));
        up_addr_valid       = 1'b0;
        up_write_data_valid = 1'b0;
        tick;

        // unmapped read
        applyStimulus(32'h0001_0000, 1'b0, '0);
        checkOutput("unmap_err", 512'({up_read_data_ready, up_error}), 512'(2'b11));
        checkOutput("unmap_cs", 512'({rom_cs, ram_cs}), 512'(2'b00));
        tick;
        checkQuiet("unmap_after");

        // stalled ram read
        applyStimulus(32'h0000_8000, 1'b0, '0);
`ifdef BUS_DECODER_TIMEOUT_EN
        repeat (63) tick;
        checkOutput("tmo_n64", 512'({ram_cs, up_read_data_ready}), 512'(2'b10));
        tick;
        checkOutput("tmo_err", 512'({up_read_data_ready, up_error}), 512'(2'b11));
        checkOutput("tmo_csoff", 512'(ram_cs), 512'(1'b0));
        tick;
        checkQuiet("tmo_after");
`else
        repeat (79) tick;
        checkOutput("wait_busy", 512'({ram_cs, up_read_data_ready}), 512'(2'b10));
        ram_data_ready = 1'b1;
        tick;
        ram_data_ready = 1'b0;
        checkOutput("wait_done", 512'({up_read_data_ready, up_error}), 512'(2'b10));
        checkOutput("wait_data", up_read_data, RAM_PAT);
        tick;
`endif
        romRead("second");

        // reset during BUSY beats a simultaneous target ready
        applyStimulus(32'h0000_0200, 1'b0, '0);
        rst            = 1'b1;
        rom_data_ready = 1'b1;
        tick;
        rst            = 1'b0;
        rom_data_ready = 1'b0;
        checkQuiet("rstbusy");
        tick;
        checkQuiet("rstbusy_next");
        romRead("post_rst");

        // rom read must ignore a ram ready held high
        ram_data_ready = 1'b1;
        applyStimulus(32'h0000_0300, 1'b0, '0);
        checkOutput("ign_cs1", 512'({rom_cs, ram_cs}), 512'(2'b10));
        tick;
        checkOutput("ign_noready", 512'(up_read_data_ready), 512'(1'b0));
        checkOutput("ign_cs2", 512'(rom_cs), 512'(1'b1));
        rom_data_ready = 1'b1;
        tick;
        rom_data_ready = 1'b0;
        ram_data_ready = 1'b0;
        checkOutput("ign_ready", 512'({up_read_data_ready, up_error}), 512'(2'b10));
        checkOutput("ign_data", up_read_data, ROM_PAT);
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
